// File: rtl/riscv_mem_responder.sv
// Memory-side responder for the pipelined RISC-V core: text BRAM fetch port,
// data BRAM load/store port and a 16-byte MMIO window (LEDs, switches, counters).
module riscv_mem_responder #(
  parameter int unsigned      XLEN       = 32,
  parameter logic [XLEN-1:0]  TEXT_BASE  = 32'h00400000,
  parameter int unsigned      TEXT_WORDS = 1024,
  parameter logic [XLEN-1:0]  DATA_BASE  = 32'h00002000,
  parameter int unsigned      DATA_WORDS = 1024,
  parameter logic [XLEN-1:0]  MMIO_BASE  = 32'h0000FF00,
  parameter string            TEXT_INIT  = "",
  parameter string            DATA_INIT  = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PC,
  output logic [31:0]     instruction,
  output logic            iError,
  input  logic [XLEN-1:0] dAddress,
  input  logic [XLEN-1:0] dWriteData,
  input  logic            MemRead,
  input  logic            MemWrite,
  output logic [XLEN-1:0] dReadData,
  output logic            dError,
  input  logic [15:0]     switches,
  output logic [15:0]     leds
);

  localparam int unsigned     TAW       = $clog2(TEXT_WORDS);
  localparam int unsigned     DAW       = $clog2(DATA_WORDS);
  localparam logic [31:0]     NOP       = 32'h00000013;
  localparam logic [XLEN-1:0] TEXT_SPAN = XLEN'(4 * TEXT_WORDS);
  localparam logic [XLEN-1:0] DATA_SPAN = XLEN'(4 * DATA_WORDS);
  localparam logic [XLEN-1:0] MMIO_SPAN = XLEN'(16);

  logic [31:0]     text_mem [TEXT_WORDS];
  logic [XLEN-1:0] data_mem [DATA_WORDS];

  // Fetch path: BRAM output register has no reset; a reset-cleared valid bit
  // selects NOP so reset takes effect on the output immediately.
  logic [XLEN-1:0] text_off;
  logic            fetch_ok;
  logic [TAW-1:0]  text_idx;
  logic [31:0]     text_q;
  logic            text_valid;

  assign text_off = PC - TEXT_BASE;
  assign fetch_ok = (text_off < TEXT_SPAN) && (PC[1:0] == 2'b00);
  assign text_idx = text_off[TAW+1:2];

  always_ff @(posedge clk) begin
    text_q <= text_mem[text_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      text_valid <= 1'b0;
      iError     <= 1'b0;
    end else begin
      text_valid <= fetch_ok;
      iError     <= ~fetch_ok;
    end
  end

  assign instruction = text_valid ? text_q : NOP;

  // Data decode
  logic [XLEN-1:0] data_off;
  logic [XLEN-1:0] mmio_off;
  logic            data_hit;
  logic            mmio_hit;
  logic            d_fault;
  logic [DAW-1:0]  data_idx;
  logic [1:0]      mmio_reg;
  logic            mem_re;
  logic            mem_we;
  logic            mmio_we;

  assign data_off = dAddress - DATA_BASE;
  assign mmio_off = dAddress - MMIO_BASE;
  assign data_hit = data_off < DATA_SPAN;
  assign mmio_hit = mmio_off < MMIO_SPAN;
  assign d_fault  = (MemRead | MemWrite) &&
                    (!(data_hit || mmio_hit) || (dAddress[1:0] != 2'b00));
  assign data_idx = data_off[DAW+1:2];
  assign mmio_reg = mmio_off[3:2];
  assign mem_re   = MemRead  && !d_fault && data_hit;
  assign mem_we   = MemWrite && !d_fault && data_hit;
  assign mmio_we  = MemWrite && !d_fault && mmio_hit && !data_hit;

  // Read-first falls out of the non-blocking read/write on the same edge.
  logic [XLEN-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (mem_re) mem_q <= data_mem[data_idx];
    if (mem_we && !rst) data_mem[data_idx] <= dWriteData;
  end

  // MMIO registers
  logic [15:0]     sw_meta;
  logic [15:0]     sw_sync;
  logic [31:0]     cycle_cnt;
  logic [31:0]     err_cnt;
  logic [1:0]      err_inc;
  logic [32:0]     err_sum;
  logic [XLEN-1:0] mmio_rdata;
  logic [XLEN-1:0] rd_reg;
  logic            rd_sel;

  assign err_inc = {1'b0, ~fetch_ok} + {1'b0, d_fault};
  assign err_sum = {1'b0, err_cnt} + 33'(err_inc);

  always_comb begin
    mmio_rdata = '0;
    case (mmio_reg)
      2'd0: mmio_rdata = XLEN'(leds);
      2'd1: mmio_rdata = XLEN'(sw_sync);
      2'd2: mmio_rdata = XLEN'(cycle_cnt);
      2'd3: mmio_rdata = XLEN'(err_cnt);
      default: mmio_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sel    <= 1'b0;
      rd_reg    <= '0;
      dError    <= 1'b0;
      leds      <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
      cycle_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      dError  <= d_fault;
      sw_meta <= switches;
      sw_sync <= sw_meta;
      if (MemRead) begin
        rd_sel <= mem_re;
        rd_reg <= (d_fault || data_hit) ? '0 : mmio_rdata;
      end
      if (mmio_we && mmio_reg == 2'd0) leds <= dWriteData[15:0];
      cycle_cnt <= (mmio_we && mmio_reg == 2'd2) ? '0 : cycle_cnt + 32'd1;
      if (mmio_we && mmio_reg == 2'd3) err_cnt <= '0;
      else if (err_sum[32])            err_cnt <= '1;
      else                             err_cnt <= err_sum[31:0];
    end
  end

  assign dReadData = rd_sel ? mem_q : rd_reg;

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Randomized bench for riscv_mem_responder against an address-map level model.
module tb_riscv_mem_responder;

  localparam logic [31:0] TB  = 32'h00400000;
  localparam logic [31:0] DB  = 32'h00002000;
  localparam logic [31:0] MB  = 32'h0000FF00;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam int          TW  = 1024;
  localparam int          DW  = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = TB, daddr = '0, wdata = '0;
  logic        mrd = 1'b0, mwr = 1'b0;
  logic [15:0] sw = '0;
  logic [31:0] instruction, dreaddata;
  logic        ierror, derror;
  logic [15:0] leds;

  always #5 clk = ~clk;

  riscv_mem_responder #(
    .XLEN(32), .TEXT_BASE(TB), .TEXT_WORDS(TW),
    .DATA_BASE(DB), .DATA_WORDS(DW), .MMIO_BASE(MB)
  ) dut (
    .clk(clk), .rst(rst), .PC(pc), .instruction(instruction), .iError(ierror),
    .dAddress(daddr), .dWriteData(wdata), .MemRead(mrd), .MemWrite(mwr),
    .dReadData(dreaddata), .dError(derror), .switches(sw), .leds(leds)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_text [TW];
  logic [31:0] m_data [DW];
  logic [15:0] m_leds, m_sw1, m_sw2;
  logic [31:0] m_cyc, m_err, m_rd;
  logic        m_ierr, m_derr;
  logic [31:0] m_instr;

  task automatic model_reset();
    m_leds = '0; m_sw1 = '0; m_sw2 = '0; m_cyc = '0; m_err = '0;
    m_rd = '0; m_ierr = 1'b0; m_derr = 1'b0; m_instr = NOP;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".instr"}, instruction, m_instr);
    check({tag, ".ierr"}, {31'b0, ierror}, {31'b0, m_ierr});
    check({tag, ".rdata"}, dreaddata, m_rd);
    check({tag, ".derr"}, {31'b0, derror}, {31'b0, m_derr});
    check({tag, ".leds"}, {16'b0, leds}, {16'b0, m_leds});
  endtask

  // One clock: drive at negedge, predict, check just after the rising edge.
  task automatic step(input string tag, input logic [31:0] p, input logic [31:0] a,
                      input logic [31:0] w, input logic r, input logic wr);
    logic        fok, indata, inmmio, fault;
    logic [31:0] moff;
    logic [33:0] s;
    pc = p; daddr = a; wdata = w; mrd = r; mwr = wr;
    if (rst) begin
      model_reset();
    end else begin
      fok     = (p >= TB) && (p < TB + 4 * TW) && (p[1:0] == 2'b00);
      m_instr = fok ? m_text[(p - TB) >> 2] : NOP;
      m_ierr  = !fok;
      indata  = (a >= DB) && (a < DB + 4 * DW);
      inmmio  = (a >= MB) && (a < MB + 16);
      moff    = a - MB;
      fault   = (r || wr) && (!(indata || inmmio) || (a[1:0] != 2'b00));
      m_derr  = fault;
      if (r) begin
        if (fault)       m_rd = '0;
        else if (indata) m_rd = m_data[(a - DB) >> 2];
        else case (moff)
          32'd0:   m_rd = {16'b0, m_leds};
          32'd4:   m_rd = {16'b0, m_sw2};
          32'd8:   m_rd = m_cyc;
          default: m_rd = m_err;
        endcase
      end
      s = {2'b0, m_err} + 34'(m_ierr) + 34'(fault);
      m_err = (s > 34'h0FFFFFFFF) ? 32'hFFFFFFFF : s[31:0];
      m_cyc = m_cyc + 1;
      if (wr && !fault) begin
        if (indata) m_data[(a - DB) >> 2] = w;
        else if (moff == 0)  m_leds = w[15:0];
        else if (moff == 8)  m_cyc = '0;
        else if (moff == 12) m_err = '0;
      end
      m_sw2 = m_sw1;
      m_sw1 = sw;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", TB, DB, '0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 9))
      0:       return TB + 4 * (TW - 1);
      1:       return TB + 32'h1000;
      2:       return TB + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
      default: return TB + 32'(4 * $urandom_range(0, 7));
    endcase
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 11))
      0, 1, 2, 3: return DB + 32'(4 * $urandom_range(0, 15));
      4:          return DB + 4 * (DW - 1);
      5, 6, 7:    return MB + 32'(4 * $urandom_range(0, 3));
      8:          return DB + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      9:          return DB - 4;
      10:         return DB + 4 * DW;
      default:    return MB + 16;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) m_text[i] = $urandom;
    m_text[0]      = 32'h00500093;
    m_text[TW - 1] = 32'hCAFEF00D;
    for (int i = 0; i < 8; i++) dut.text_mem[i] = m_text[i];
    dut.text_mem[TW - 1] = m_text[TW - 1];

    model_reset();
    #1 rst = 1'b1;
    #1 check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) step("zero", TB, DB + 32'(4 * i), '0, 1'b0, 1'b1);
    step("zero_last", TB, DB + 4 * (DW - 1), '0, 1'b0, 1'b1);

    // Fetch boundaries
    step("fetch0", TB, DB, '0, 1'b0, 1'b0);
    step("fetch_end", TB + 32'h1000, DB, '0, 1'b0, 1'b0);
    step("fetch_last", TB + 4 * (TW - 1), DB, '0, 1'b0, 1'b0);
    step("fetch_misal", TB + 2, DB, '0, 1'b0, 1'b0);
    step("fetch_below", TB - 4, DB, '0, 1'b0, 1'b0);

    // Store, load, hold
    step("st", TB, DB + 4, 32'hDEADBEEF, 1'b0, 1'b1);
    step("ld", TB, DB + 4, '0, 1'b1, 1'b0);
    idle(2);

    // Read-first
    step("rw", TB, DB + 8, 32'h12345678, 1'b1, 1'b1);
    step("ld_rw", TB, DB + 8, '0, 1'b1, 1'b0);

    // Faults and error counter
    step("clr_err", TB, MB + 12, '0, 1'b0, 1'b1);
    step("ld_misal", TB, DB + 2, '0, 1'b1, 1'b0);
    step("st_oor", TB, 32'h00001000, 32'h55555555, 1'b0, 1'b1);
    idle(1);
    step("ld_err", TB, MB + 12, '0, 1'b1, 1'b0);
    step("ld_after", TB, DB + 4, '0, 1'b1, 1'b0);

    // MMIO
    step("st_leds", TB, MB, 32'h0000A5A5, 1'b0, 1'b1);
    sw = 16'h3C3C;
    idle(3);
    step("ld_sw", TB, MB + 4, '0, 1'b1, 1'b0);
    step("st_sw", TB, MB + 4, 32'hFFFFFFFF, 1'b0, 1'b1);
    step("clr_cyc", TB, MB + 8, '0, 1'b0, 1'b1);
    idle(3);
    step("ld_cyc", TB, MB + 8, '0, 1'b1, 1'b0);
    step("clr_vs_inc", TB + 32'h1000, MB + 12, '0, 1'b0, 1'b1);
    idle(1);
    step("ld_err0", TB, MB + 12, '0, 1'b1, 1'b0);

    // Data and MMIO window edges
    step("st_lastd", TB, DB + 4 * (DW - 1), 32'h0BADF00D, 1'b0, 1'b1);
    step("ld_lastd", TB, DB + 4 * (DW - 1), '0, 1'b1, 1'b0);
    step("ld_pastd", TB, DB + 4 * DW, '0, 1'b1, 1'b0);
    step("ld_pastm", TB, MB + 16, '0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
      step("rand", pick_pc(), pick_addr(), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
    end

    // Reset mid-load, with a store coincident with reset
    step("pre_leds", TB, MB, 32'h0000A5A5, 1'b0, 1'b1);
    step("pre_st", TB, DB + 4, 32'hDEADBEEF, 1'b0, 1'b1);
    step("pre_ld", TB, DB + 4, '0, 1'b1, 1'b0);
    daddr = DB + 4; mrd = 1'b1;
    rst = 1'b1;
    model_reset();
    #1 check_outputs("async_rst");
    @(negedge clk);
    step("rst_st", TB, DB + 4, 32'h11111111, 1'b0, 1'b1);
    rst = 1'b0;
    step("post_ld", TB, DB + 4, '0, 1'b1, 1'b0);
    step("post_cyc", TB, MB + 8, '0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
